wb_stage_grf: RTL and testbench

- Writeback stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the W-stage pipeline register outputs (instr, pc, DM read data, destination, ALU/MDU results).
- Selects and extends the writeback value, then commits it to a 32x32 register file.
- Serves the two D-stage read ports with write-through bypass, and exports the W-stage write data and enable for hazard forwarding plus a retired-instruction counter.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/wb_stage_grf_regfile.sv | 47 ++++
 rtl/wb_stage_grf.sv | 116 +++++++++++
 tb/tb_wb_stage_grf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct encodings and writeback-source selector
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC8 = 2'd2,
    WD_MDU = 2'd3
  } wd_sel_t;

endpackage

// File: rtl/wb_stage_grf_regfile.sv
// rtl/wb_stage_grf_regfile.sv - 32x32 register file with one write port and two write-through read ports
module grf_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra_a,
  input  logic [4:0]  i_ra_b,
  output logic [31:0] o_rd_a,
  output logic [31:0] o_rd_b
);

  logic [31:0] r_regs [32];

  // Reset wins over a write arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    if (i_ra_a == 5'd0)
      o_rd_a = '0;
    else if (i_we && (i_ra_a == i_wa))
      o_rd_a = i_wd;
    else
      o_rd_a = r_regs[i_ra_a];
  end

  always_comb begin
    if (i_ra_b == 5'd0)
      o_rd_b = '0;
    else if (i_we && (i_ra_b == i_wa))
      o_rd_b = i_wd;
    else
      o_rd_b = r_regs[i_ra_b];
  end

endmodule

// File: rtl/wb_stage_grf.sv
// rtl/wb_stage_grf.sv - writeback select/extend, register file commit and retire counter
module wb_stage_grf
  import mips_pkg::*;
#(
  parameter int unsigned PC_LINK_OFFSET = 8,
  parameter int unsigned RETIRE_CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             W_instr,
  input  logic [31:0]             W_pc,
  input  logic [31:0]             W_DM_RD,
  input  logic [4:0]              W_GRF_WA,
  input  logic [31:0]             W_ALU_result,
  input  logic [31:0]             W_MDU_result,
  input  logic [4:0]              D_rs_addr,
  input  logic [4:0]              D_rt_addr,
  output logic [31:0]             D_rs_data,
  output logic [31:0]             D_rt_data,
  output logic                    W_GRF_WE,
  output logic [31:0]             W_GRF_WD,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [1:0]  w_addr;
  wd_sel_t     w_sel;
  logic        w_writes;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [RETIRE_CNT_W-1:0] r_retire_count;

  assign w_op   = W_instr[31:26];
  assign w_fn   = W_instr[5:0];
  assign w_addr = W_ALU_result[1:0];

  always_comb begin
    w_sel    = WD_ALU;
    w_writes = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        case (w_fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: w_writes = 1'b1;
          FN_MFHI, FN_MFLO: begin
            w_sel    = WD_MDU;
            w_writes = 1'b1;
          end
          default: w_writes = 1'b0;
        endcase
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        w_sel    = WD_DM;
        w_writes = 1'b1;
      end
      OP_JAL: begin
        w_sel    = WD_PC8;
        w_writes = 1'b1;
      end
      OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: w_writes = 1'b1;
      default: w_writes = 1'b0;
    endcase
  end

  // Little-endian lane pick; halfword ignores a[0], so misaligned lh reads the aligned half.
  always_comb begin
    case (w_addr)
      2'd0:    w_byte = W_DM_RD[7:0];
      2'd1:    w_byte = W_DM_RD[15:8];
      2'd2:    w_byte = W_DM_RD[23:16];
      default: w_byte = W_DM_RD[31:24];
    endcase
    w_half = w_addr[1] ? W_DM_RD[31:16] : W_DM_RD[15:0];
    case (w_op)
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load = {16'h0, w_half};
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load = {24'h0, w_byte};
      default: w_load = W_DM_RD;
    endcase
  end

  always_comb begin
    case (w_sel)
      WD_DM:   W_GRF_WD = w_load;
      WD_PC8:  W_GRF_WD = W_pc + 32'(PC_LINK_OFFSET);
      WD_MDU:  W_GRF_WD = W_MDU_result;
      default: W_GRF_WD = W_ALU_result;
    endcase
  end

  assign W_GRF_WE = w_writes && (W_GRF_WA != 5'd0);

  always_ff @(posedge clk) begin
    if (reset)
      r_retire_count <= '0;
    else if (|W_instr)
      r_retire_count <= r_retire_count + RETIRE_CNT_W'(1);
  end

  assign retire_count = r_retire_count;

  grf_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .i_we   (W_GRF_WE),
    .i_wa   (W_GRF_WA),
    .i_wd   (W_GRF_WD),
    .i_ra_a (D_rs_addr),
    .i_ra_b (D_rt_addr),
    .o_rd_a (D_rs_data),
    .o_rd_b (D_rt_data)
  );

endmodule

// File: tb/tb_wb_stage_grf.sv
// tb/tb_wb_stage_grf.sv - directed scoreboard bench for wb_stage_grf
module tb_wb_stage_grf;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_instr, W_pc, W_DM_RD, W_ALU_result, W_MDU_result;
  logic [4:0]  W_GRF_WA, D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_GRF_WD, retire_count;
  logic        W_GRF_WE;
  logic [31:0] s_rs_data, s_rt_data, s_wd;
  logic        s_we;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;
  int unsigned exp_count = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  wb_stage_grf dut (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_pc(W_pc), .W_DM_RD(W_DM_RD),
    .W_GRF_WA(W_GRF_WA), .W_ALU_result(W_ALU_result), .W_MDU_result(W_MDU_result),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .W_GRF_WE(W_GRF_WE), .W_GRF_WD(W_GRF_WD), .retire_count(retire_count)
  );

  wb_stage_grf #(.RETIRE_CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_pc(W_pc), .W_DM_RD(W_DM_RD),
    .W_GRF_WA(W_GRF_WA), .W_ALU_result(W_ALU_result), .W_MDU_result(W_MDU_result),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rs_data(s_rs_data), .D_rt_data(s_rt_data),
    .W_GRF_WE(s_we), .W_GRF_WD(s_wd), .retire_count(s_count)
  );

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h12345, fn};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (val_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic set_w(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] dm,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] mdu);
    W_instr = instr; W_pc = pc; W_DM_RD = dm; W_GRF_WA = wa; W_ALU_result = alu; W_MDU_result = mdu;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset && W_instr != 32'h0) exp_count++;
    #1;
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a, input logic [31:0] ea,
                           input logic [4:0] b, input logic [31:0] eb);
    D_rs_addr = a; D_rt_addr = b;
    push({tag, "_rs"}, ea);
    push({tag, "_rt"}, eb);
    #1;
    pop_check(D_rs_data);
    pop_check(D_rt_data);
  endtask

  task automatic check_count(input string tag);
    push(tag, exp_count);
    pop_check(retire_count);
  endtask

  task automatic load_case(input string tag, input logic [5:0] op, input logic [4:0] wa,
                           input logic [1:0] a, input logic [31:0] exp_wd);
    set_w(mk_i(op, 6'h00), 32'h0, 32'h80FF7F01, wa, {30'h0, a}, 32'h0);
    push({tag, "_wd"}, exp_wd);
    push({tag, "_we"}, 32'h1);
    #1;
    pop_check(W_GRF_WD);
    pop_check({31'h0, W_GRF_WE});
    step();
  endtask

  initial begin
    reset = 1'b1;
    D_rs_addr = 5'd0; D_rt_addr = 5'd0;
    set_w(32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
    exp_count = 0;
    check_count("reset_count");
    for (int i = 0; i < 32; i++) read_pair("reset_read", 5'(i), 32'h0, 5'(31 - i), 32'h0);

    set_w({OP_ORI, 26'h0A5BEEF}, 32'h0, 32'h0, 5'd5, 32'h0000BEEF, 32'h0);
    push("ori_we", 32'h1);
    #1;
    pop_check({31'h0, W_GRF_WE});
    read_pair("ori_bypass", 5'd5, 32'h0000BEEF, 5'd6, 32'h0);
    step();
    set_w(32'h0, 32'h0, 32'h0, 5'd5, 32'h0, 32'h0);
    read_pair("ori_commit", 5'd5, 32'h0000BEEF, 5'd0, 32'h0);
    check_count("ori_count");

    load_case("lb_a2",  OP_LB,  5'd10, 2'd2, 32'hFFFFFFFF);
    load_case("lbu_a3", OP_LBU, 5'd11, 2'd3, 32'h00000080);
    load_case("lh_a2",  OP_LH,  5'd12, 2'd2, 32'hFFFF80FF);
    load_case("lhu_a0", OP_LHU, 5'd13, 2'd0, 32'h00007F01);
    load_case("lw",     OP_LW,  5'd14, 2'd1, 32'h80FF7F01);
    load_case("lbu_a1", OP_LBU, 5'd15, 2'd1, 32'h0000007F);

    set_w({OP_JAL, 26'h0000C00}, 32'h00003000, 32'h0, 5'd31, 32'h0, 32'h0);
    step();
    set_w(mk_i(OP_SPECIAL, FN_MFLO), 32'h0, 32'h0, 5'd8, 32'hFFFFFFFF, 32'h12345678);
    step();
    set_w(32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    read_pair("jal_mflo", 5'd31, 32'h00003008, 5'd8, 32'h12345678);
    read_pair("lb_lbu", 5'd10, 32'hFFFFFFFF, 5'd11, 32'h00000080);
    read_pair("lh_lhu", 5'd12, 32'hFFFF80FF, 5'd13, 32'h00007F01);
    read_pair("lw_lbu1", 5'd14, 32'h80FF7F01, 5'd15, 32'h0000007F);
    check_count("load_count");

    set_w(mk_i(OP_SPECIAL, FN_ADD), 32'h0, 32'h0, 5'd9, 32'h0000CAFE, 32'h0);
    read_pair("dual_bypass", 5'd9, 32'h0000CAFE, 5'd9, 32'h0000CAFE);
    step();

    set_w(mk_i(OP_ADDI, 6'h00), 32'h0, 32'h0, 5'd0, 32'hDEADBEEF, 32'h0);
    push("addi_r0_we", 32'h0);
    #1;
    pop_check({31'h0, W_GRF_WE});
    read_pair("addi_r0_read", 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    check_count("addi_r0_count");
    set_w(mk_i(OP_SW, 6'h00), 32'h0, 32'h0, 5'd5, 32'h11111111, 32'h0);
    push("sw_we", 32'h0);
    #1;
    pop_check({31'h0, W_GRF_WE});
    step();
    set_w(mk_i(OP_BEQ, 6'h00), 32'h0, 32'h0, 5'd5, 32'h22222222, 32'h0);
    step();
    set_w(mk_i(OP_SPECIAL, FN_MULT), 32'h0, 32'h0, 5'd5, 32'h33333333, 32'h44444444);
    push("mult_we", 32'h0);
    #1;
    pop_check({31'h0, W_GRF_WE});
    step();
    set_w(32'h0, 32'h0, 32'h0, 5'd5, 32'h55555555, 32'h0);
    step();
    read_pair("no_write_r5", 5'd5, 32'h0000BEEF, 5'd9, 32'h0000CAFE);
    check_count("nonwrite_count");

    set_w(mk_i(OP_SPECIAL, FN_OR), 32'h0, 32'h0, 5'd5, 32'h5A5A5A5A, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 0;
    set_w(32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    read_pair("reset_drop", 5'd5, 32'h0, 5'd31, 32'h0);
    check_count("reset_mid_count");

    for (int i = 0; i < 15; i++) begin
      set_w(mk_i(OP_SW, 6'h00), 32'h0, 32'h0, 5'd1, 32'h0, 32'h0);
      step();
    end
    push("small_all_ones", 32'h0000000F);
    #1;
    pop_check({28'h0, s_count});
    step();
    set_w(32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    push("small_wrap", 32'h0);
    #1;
    pop_check({28'h0, s_count});
    check_count("wide_count_16");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
